// File: rtl/note_judge.sv
// note_judge: judges button presses against the falling notes of four lanes.
//
// Sits between the four note movers and the score/HUD renderer (i_clk domain).
// Each lane runs a small IDLE/ZONE/RETIRE tracker. The tracker reports a hit,
// a miss or a stray press, and gates the lane's mover enable so that a hit
// note is sent back to the top. Score, combo, max combo and miss count are
// kept here, and a sticky game-over flag is raised.
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_ani_stb        frame strobe shared with the movers
//   i_active         game running
//   i_note_state     lane i: bit 2i = note in push zone, bit 2i+1 = note at bottom
//   i_btn            debounced button levels, one per lane
//   o_lane_en        registered enable to each mover
//   o_hit/o_miss/o_stray  one-cycle judgement pulses per lane
//   o_score          saturating score
//   o_combo          consecutive-hit count (saturates at 255)
//   o_max_combo      highest combo since reset
//   o_misses         miss count (saturates at MAX_MISSES)
//   o_game_over      sticky end-of-game flag
module note_judge #(
   parameter int SCORE_W    = 16,
   parameter int HIT_PTS    = 10,
   parameter int COMBO_STEP = 10,
   parameter int MAX_MULT   = 4,
   parameter int MAX_MISSES = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_ani_stb,
   input  logic               i_active,
   input  logic [7:0]         i_note_state,
   input  logic [3:0]         i_btn,
   output logic [3:0]         o_lane_en,
   output logic [3:0]         o_hit,
   output logic [3:0]         o_miss,
   output logic [3:0]         o_stray,
   output logic [SCORE_W-1:0] o_score,
   output logic [7:0]         o_combo,
   output logic [7:0]         o_max_combo,
   output logic [2:0]         o_misses,
   output logic               o_game_over
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ZONE   = 2'd1;
   localparam logic [1:0] ST_RETIRE = 2'd2;

   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                    input logic [31:0] g);
      logic [SCORE_W+32:0] sum;
      sum = (SCORE_W+33)'(s) + (SCORE_W+33)'(g);
      if (sum > (SCORE_W+33)'({SCORE_W{1'b1}})) return {SCORE_W{1'b1}};
      return sum[SCORE_W-1:0];
   endfunction

   function automatic logic [7:0] sat_combo(input logic [7:0] c, input logic [2:0] h);
      logic [8:0] sum;
      sum = {1'b0, c} + {6'd0, h};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   function automatic logic [2:0] sat_misses(input logic [2:0] m, input logic [2:0] add);
      logic [3:0] sum;
      sum = {1'b0, m} + {1'b0, add};
      if (sum >= 4'(MAX_MISSES)) return 3'(MAX_MISSES);
      return sum[2:0];
   endfunction

   function automatic logic [2:0] count4(input logic [3:0] v);
      return {2'd0, v[0]} + {2'd0, v[1]} + {2'd0, v[2]} + {2'd0, v[3]};
   endfunction

   logic [3:0][1:0]    lane_st, next_st;
   logic [3:0]         btn_prev, bot_prev;
   logic [3:0]         zone, bot, press, bot_rise;
   logic [3:0]         hit_d, miss_d, stray_d, en_d;
   logic               run;
   logic [2:0]         h_cnt, m_cnt, s_cnt;
   logic [31:0]        mult, gain;
   logic [SCORE_W-1:0] score_d;
   logic [7:0]         combo_d, max_d;
   logic [2:0]         misses_d;
   logic               go_d;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         zone[i] = i_note_state[2*i];
         bot[i]  = i_note_state[2*i+1];
      end
   end

   assign press    = i_btn & ~btn_prev;
   assign bot_rise = bot & ~bot_prev;
   assign run      = i_active & ~o_game_over;

   // Per-lane judgement; when not running every lane collapses to IDLE.
   always_comb begin
      next_st = lane_st;
      hit_d   = '0;
      miss_d  = '0;
      stray_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (!run) begin
            next_st[i] = ST_IDLE;
         end else begin
            case (lane_st[i])
               ST_IDLE: begin
                  stray_d[i] = press[i];
                  miss_d[i]  = bot_rise[i];
                  if (zone[i] && !press[i] && !bot_rise[i]) next_st[i] = ST_ZONE;
               end
               ST_ZONE: begin
                  // A press wins over a simultaneous bottom arrival.
                  if (press[i]) begin
                     hit_d[i]   = 1'b1;
                     next_st[i] = ST_RETIRE;
                  end else if (bot_rise[i]) begin
                     miss_d[i]  = 1'b1;
                     next_st[i] = ST_IDLE;
                  end else if (!zone[i]) begin
                     next_st[i] = ST_IDLE;
                  end
               end
               ST_RETIRE: begin
                  // The mover sees enable low on this strobe and restarts at the top.
                  if (i_ani_stb) next_st[i] = ST_IDLE;
               end
               default: next_st[i] = ST_IDLE;
            endcase
         end
      end
   end

   // Scoring: every hit in a cycle shares the multiplier of the pre-cycle combo.
   always_comb begin
      h_cnt = count4(hit_d);
      m_cnt = count4(miss_d);
      s_cnt = count4(stray_d);
      mult  = 32'(o_combo) / 32'(COMBO_STEP) + 32'd1;
      if (mult > 32'(MAX_MULT)) mult = 32'(MAX_MULT);
      gain     = 32'(h_cnt) * 32'(HIT_PTS) * mult;
      score_d  = sat_score(o_score, gain);
      combo_d  = ((m_cnt != 3'd0) || (s_cnt != 3'd0)) ? {5'd0, h_cnt}
                                                      : sat_combo(o_combo, h_cnt);
      max_d    = (combo_d > o_max_combo) ? combo_d : o_max_combo;
      misses_d = sat_misses(o_misses, m_cnt);
      go_d     = o_game_over | (run & (misses_d == 3'(MAX_MISSES)));
      for (int i = 0; i < 4; i++)
         en_d[i] = i_active & ~go_d & (next_st[i] != ST_RETIRE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lane_st     <= '0;
         btn_prev    <= '0;
         bot_prev    <= '0;
         o_lane_en   <= '0;
         o_hit       <= '0;
         o_miss      <= '0;
         o_stray     <= '0;
         o_score     <= '0;
         o_combo     <= '0;
         o_max_combo <= '0;
         o_misses    <= '0;
         o_game_over <= 1'b0;
      end else begin
         btn_prev  <= i_btn;
         bot_prev  <= bot;
         lane_st   <= next_st;
         o_lane_en <= en_d;
         o_hit     <= hit_d;
         o_miss    <= miss_d;
         o_stray   <= stray_d;
         if (run) begin
            o_score     <= score_d;
            o_combo     <= combo_d;
            o_max_combo <= max_d;
            o_misses    <= misses_d;
            o_game_over <= go_d;
         end
      end
   end

endmodule
